// File: rtl/inst_sequencer.sv
// Instruction-cycle sequencer for the 4-bit CPU: 8-phase machine cycle,
// OPR/OPA latching, two-word jump tracking and PC nibble write-back.
//
// Ports:
//   clock            system clock, rising edge
//   reset_n          asynchronous active-low reset
//   data[3:0]        instruction nibble bus (OPR in cycle 3, OPA in cycle 4)
//   cond_in          JCN condition, sampled in cycle 7
//   cycle[2:0]       current phase 0..7 (registered)
//   opr[3:0]         latched upper nibble of current word
//   opa[3:0]         latched lower nibble of current word
//   second_word      second word of a two-word instruction in flight
//   halt             sticky halt to the PC stage
//   pc_next_sel[1:0] PC source select
//   pc_write_enable  bit1 = PC high nibble, bit0 = PC low nibble
//   jump_data[3:0]   nibble loaded into the PC
//   reg_addr[3:0]    register-file index for JIN
//
// Optional feature: define JIN_EN to enable the register-indirect JIN jump.

module inst_sequencer #(
    parameter logic [1:0] PC_SEL_DATA = 2'd0
`ifdef JIN_EN
    ,
    parameter logic [1:0] PC_SEL_REG  = 2'd1
`endif
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] data,
    input  logic       cond_in,
    output logic [2:0] cycle,
    output logic [3:0] opr,
    output logic [3:0] opa,
    output logic       second_word,
    output logic       halt,
    output logic [1:0] pc_next_sel,
    output logic [1:0] pc_write_enable,
    output logic [3:0] jump_data,
    output logic [3:0] reg_addr
);

    logic taken;
    logic decode;
    logic is_jun;
    logic is_jcn;
    logic is_hlt;
    logic pending;

    // Only a first word reaching cycle 7 is decoded.
    assign decode  = (cycle == 3'd7) && !second_word && !halt;
    assign is_jun  = (opr == 4'h4);
    assign is_jcn  = (opr == 4'h1);
    assign is_hlt  = (opr == 4'h0) && (opa == 4'h1);
    // A jump decode launches its second word at the same 7->0 wrap.
    assign pending = decode && (is_jun || is_jcn);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle       <= 3'd0;
            opr         <= 4'h0;
            opa         <= 4'h0;
            second_word <= 1'b0;
            halt        <= 1'b0;
            taken       <= 1'b0;
        end else if (!halt) begin
            cycle <= cycle + 3'd1;
            if (cycle == 3'd3) opr <= data;
            if (cycle == 3'd4) opa <= data;
            if (cycle == 3'd7) begin
                if (second_word) begin
                    second_word <= 1'b0;
                    taken       <= 1'b0;
                end else if (pending) begin
                    second_word <= 1'b1;
                    taken       <= is_jun ? 1'b1 : (cond_in ^ opa[3]);
                end else if (is_hlt) begin
                    halt <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        pc_write_enable = 2'b00;
        pc_next_sel     = PC_SEL_DATA;
        jump_data       = 4'h0;
        reg_addr        = 4'h0;
        if (!halt) begin
            if (second_word && taken) begin
                if (cycle == 3'd5) begin
                    pc_write_enable = 2'b10;
                    jump_data       = opr;
                end else if (cycle == 3'd6) begin
                    pc_write_enable = 2'b01;
                    jump_data       = opa;
                end
            end
`ifdef JIN_EN
            else if (!second_word && (opr == 4'h3) && opa[0]) begin
                if (cycle == 3'd5) begin
                    pc_write_enable = 2'b10;
                    pc_next_sel     = PC_SEL_REG;
                    reg_addr        = {opa[3:1], 1'b0};
                end else if (cycle == 3'd6) begin
                    pc_write_enable = 2'b01;
                    pc_next_sel     = PC_SEL_REG;
                    reg_addr        = {opa[3:1], 1'b1};
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed self-checking bench for inst_sequencer.
// Drives one instruction word per 8-phase cycle and checks each phase.

module tb_inst_sequencer;

    logic       clock;
    logic       reset_n;
    logic [3:0] data;
    logic       cond_in;
    logic [2:0] cycle;
    logic [3:0] opr;
    logic [3:0] opa;
    logic       second_word;
    logic       halt;
    logic [1:0] pc_next_sel;
    logic [1:0] pc_write_enable;
    logic [3:0] jump_data;
    logic [3:0] reg_addr;

    int passed;
    int total;

    logic [1:0] we_s [8];
    logic [3:0] jd_s [8];
    logic [1:0] sel_s[8];
    logic [3:0] ra_s [8];

    inst_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data           (data),
        .cond_in        (cond_in),
        .cycle          (cycle),
        .opr            (opr),
        .opa            (opa),
        .second_word    (second_word),
        .halt           (halt),
        .pc_next_sel    (pc_next_sel),
        .pc_write_enable(pc_write_enable),
        .jump_data      (jump_data),
        .reg_addr       (reg_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs phases 0..n-1 of one word, checking cycle and second_word.
    task automatic word(input logic [3:0] hi, input logic [3:0] lo,
                        input logic c, input logic exp_sw, input int n);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("cycle%0d", k), {5'd0, cycle}, k[7:0]);
            chk($sformatf("sw%0d", k), {7'd0, second_word}, {7'd0, exp_sw});
            we_s[k]  = pc_write_enable;
            jd_s[k]  = jump_data;
            sel_s[k] = pc_next_sel;
            ra_s[k]  = reg_addr;
            data     = (k == 3) ? hi : (k == 4) ? lo : 4'hF;
            cond_in  = c;
            if (k < n - 1 || n == 8) tick();
        end
    endtask

    task automatic expect_writes(input string tag, input logic w,
                                 input logic [3:0] d5, input logic [3:0] d6);
        for (int k = 0; k < 8; k++) begin
            logic [1:0] ew;
            ew = (w && k == 5) ? 2'b10 : (w && k == 6) ? 2'b01 : 2'b00;
            chk($sformatf("%s_we%0d", tag, k), {6'd0, we_s[k]}, {6'd0, ew});
        end
        if (w) begin
            chk({tag, "_jd5"}, {4'd0, jd_s[5]}, {4'd0, d5});
            chk({tag, "_jd6"}, {4'd0, jd_s[6]}, {4'd0, d6});
            chk({tag, "_sel5"}, {6'd0, sel_s[5]}, 8'd0);
            chk({tag, "_sel6"}, {6'd0, sel_s[6]}, 8'd0);
        end
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        reset_n = 1'b0;
        data    = 4'hF;
        cond_in = 1'b0;
        tick();
        tick();
        chk("rst_cycle", {5'd0, cycle}, 8'd0);
        chk("rst_opr", {4'd0, opr}, 8'd0);
        chk("rst_opa", {4'd0, opa}, 8'd0);
        chk("rst_sw", {7'd0, second_word}, 8'd0);
        chk("rst_halt", {7'd0, halt}, 8'd0);
        chk("rst_we", {6'd0, pc_write_enable}, 8'd0);
        chk("rst_jd", {4'd0, jump_data}, 8'd0);
        chk("rst_ra", {4'd0, reg_addr}, 8'd0);
        chk("rst_sel", {6'd0, pc_next_sel}, 8'd0);
        reset_n = 1'b1;

        // Free run with an all-F word.
        word(4'hF, 4'hF, 1'b0, 1'b0, 8);
        expect_writes("free", 1'b0, 4'h0, 4'h0);
        chk("free_opr", {4'd0, opr}, 8'h0F);
        chk("free_opa", {4'd0, opa}, 8'h0F);
        chk("free_wrap", {5'd0, cycle}, 8'd0);

        // JUN 0xA5.
        word(4'h4, 4'h0, 1'b0, 1'b0, 8);
        expect_writes("jun1", 1'b0, 4'h0, 4'h0);
        word(4'hA, 4'h5, 1'b0, 1'b1, 8);
        expect_writes("jun2", 1'b1, 4'hA, 4'h5);
        chk("jun_sw_clr", {7'd0, second_word}, 8'd0);

        // JCN opa=0, cond=0: not taken, second word skipped.
        word(4'h1, 4'h0, 1'b0, 1'b0, 8);
        word(4'h2, 4'h2, 1'b0, 1'b1, 8);
        expect_writes("jcn_nt", 1'b0, 4'h0, 4'h0);

        // JCN opa=0, cond=1: taken.
        word(4'h1, 4'h0, 1'b1, 1'b0, 8);
        word(4'hC, 4'h7, 1'b0, 1'b1, 8);
        expect_writes("jcn_t", 1'b1, 4'hC, 4'h7);

        // JCN opa=8 inverts the condition: cond=1 -> not taken.
        word(4'h1, 4'h8, 1'b1, 1'b0, 8);
        word(4'h9, 4'h9, 1'b1, 1'b1, 8);
        expect_writes("jcn_inv", 1'b0, 4'h0, 4'h0);

        // JUN whose second word is 0x01: jump, no halt.
        word(4'h4, 4'h0, 1'b0, 1'b0, 8);
        word(4'h0, 4'h1, 1'b0, 1'b1, 8);
        expect_writes("jun01", 1'b1, 4'h0, 4'h1);
        chk("jun01_halt", {7'd0, halt}, 8'd0);
        chk("jun01_cyc", {5'd0, cycle}, 8'd0);

        // HLT.
        word(4'h0, 4'h1, 1'b0, 1'b0, 8);
        chk("hlt_halt", {7'd0, halt}, 8'd1);
        for (int i = 0; i < 20; i++) tick();
        chk("hlt_cycle", {5'd0, cycle}, 8'd0);
        chk("hlt_halt20", {7'd0, halt}, 8'd1);
        chk("hlt_we", {6'd0, pc_write_enable}, 8'd0);
        reset_n = 1'b0;
        #1;
        chk("hlt_rst", {7'd0, halt}, 8'd0);
        reset_n = 1'b1;
        word(4'hF, 4'hF, 1'b0, 1'b0, 8);
        expect_writes("resume", 1'b0, 4'h0, 4'h0);

        // Reset at cycle 5 of a JUN second word.
        word(4'h4, 4'h0, 1'b0, 1'b0, 8);
        word(4'hA, 4'h5, 1'b0, 1'b1, 6);
        chk("mid_we_pre", {6'd0, pc_write_enable}, 8'h02);
        reset_n = 1'b0;
        #1;
        chk("mid_we", {6'd0, pc_write_enable}, 8'd0);
        chk("mid_cycle", {5'd0, cycle}, 8'd0);
        chk("mid_sw", {7'd0, second_word}, 8'd0);
        tick();
        reset_n = 1'b1;
        word(4'hF, 4'hF, 1'b0, 1'b0, 8);
        expect_writes("mid_after", 1'b0, 4'h0, 4'h0);

        // JIN 0x35.
        word(4'h3, 4'h5, 1'b0, 1'b0, 8);
`ifdef JIN_EN
        chk("jin_we5", {6'd0, we_s[5]}, 8'h02);
        chk("jin_we6", {6'd0, we_s[6]}, 8'h01);
        chk("jin_ra5", {4'd0, ra_s[5]}, 8'h04);
        chk("jin_ra6", {4'd0, ra_s[6]}, 8'h05);
        chk("jin_sel5", {6'd0, sel_s[5]}, 8'h01);
        chk("jin_sel6", {6'd0, sel_s[6]}, 8'h01);
`else
        expect_writes("jin", 1'b0, 4'h0, 4'h0);
        chk("jin_ra5", {4'd0, ra_s[5]}, 8'h00);
        chk("jin_ra6", {4'd0, ra_s[6]}, 8'h00);
`endif
        chk("jin_sw", {7'd0, second_word}, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Instruction-cycle sequencer for the 4-bit CPU; sits directly upstream of the program-counter stage and drives its `cycle`, `halt`, `pc_next_sel`, `pc_write_enable` and jump-nibble inputs.
- Runs the 8-phase machine cycle, latches OPR/OPA nibbles from the data bus and tracks two-word instructions.
- Sequences unconditional and conditional jumps as two nibble writes into the PC.

Parameters:
- PC_SEL_DATA, 2'd0, `pc_next_sel` code selecting the jump-nibble path.
- PC_SEL_REG, 2'd1, `pc_next_sel` code selecting the register-value path.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data  in  4  instruction nibble bus, sampled in cycles 3 and 4.
- cond_in  in  1  jump condition, sampled in cycle 7.
- cycle  out  3  current phase 0..7, registered.
- opr  out  4  latched upper nibble of current word.
- opa  out  4  latched lower nibble of current word.
- second_word  out  1  high while the second word of a two-word instruction is in flight.
- halt  out  1  sticky halt to PC stage.
- pc_next_sel  out  2  PC source select.
- pc_write_enable  out  2  bit1 = PC high nibble write, bit0 = PC low nibble write.
- jump_data  out  4  nibble to load into the PC.
- reg_addr  out  4  register-file index (JIN path).

Behaviour:
- Reset (async, reset_n=0): cycle=0, opr=0, opa=0, second_word=0, halt=0, internal pending/taken flags=0. Combinational outputs pc_write_enable=0, jump_data=0, reg_addr=0, pc_next_sel=PC_SEL_DATA.
- Reset deasserted mid-instruction: restarts at cycle 0 with a single-word fetch; no jump is completed.
- Cycle counter: increments 0..7, wraps 7->0 every clock while halt=0. When halt=1 it freezes at its current value.
- Cycle 3: opr<=data. Cycle 4: opa<=data. Other cycles hold both.
- Cycle 7 decode, on a first word only (second_word=0):
  - opr=4'h4 (JUN): taken<=1, pending<=1.
  - opr=4'h1 (JCN): taken<=cond_in^opa[3], pending<=1.
  - opr=4'h0 and opa=4'h1 (HLT): halt<=1.
  - Anything else: no effect.
- Cycle 7 with pending=1: second_word<=1, pending<=0 at the 7->0 wrap.
- Cycle 7 with second_word=1: second_word<=0 and taken<=0 at the end of that cycle. A second word is never decoded as an instruction, even if it holds 0x01.
- Jump write-back, combinational from registered state, zero latency:
  - second_word=1 and taken=1, cycle 5: pc_write_enable=2'b10, jump_data=opr, pc_next_sel=PC_SEL_DATA.
  - second_word=1 and taken=1, cycle 6: pc_write_enable=2'b01, jump_data=opa, pc_next_sel=PC_SEL_DATA.
  - Otherwise pc_write_enable=0.
- Not-taken JCN: second word is fetched and skipped; the PC simply increments.
- Only one pc_write_enable bit is ever high at a time. pc_write_enable is forced to 0 whenever halt=1.
- HLT: halt rises at the 7->0 edge after decode, so cycle freezes at 0. halt stays high until reset.

Optional Feature:
- JIN_EN. When defined, JIN (opr=4'h3, opa[0]=1) is a single-word register-indirect jump:
  - cycle 5: reg_addr={opa[3:1],1'b0}, pc_next_sel=PC_SEL_REG, pc_write_enable=2'b10.
  - cycle 6: reg_addr={opa[3:1],1'b1}, pc_next_sel=PC_SEL_REG, pc_write_enable=2'b01.
  - No second word is fetched.
- When undefined: reg_addr is tied to 0 and opcode 0x3 has no effect.

Test Plan:
- Reset then free run with data=4'hF -> cycle sequence 0,1,...,7,0; opr=opa=F after cycle 4; pc_write_enable always 0.
- JUN: word1 data 4 then 0, word2 data A then 5 -> second_word=1 during word2; cycle 5 we=10 jump_data=A; cycle 6 we=01 jump_data=5.
- JCN with opa=0 and cond_in=0 at cycle 7 -> second word fetched, we stays 0. Repeat with cond_in=1 -> both nibble writes occur.
- HLT word 0x01 -> halt=1 and cycle stuck at 0 for 20 clocks. Pulse reset_n low -> halt=0, counting resumes.
- JUN whose second word is 0x01 -> jump performed, no halt.
- Assert reset_n low at cycle 5 of a JUN second word -> we=0 immediately, cycle=0, second_word=0.
- (JIN_EN build) word 0x35 -> cycle 5 reg_addr=4, sel=REG, we=10; cycle 6 reg_addr=5, we=01. Non-JIN_EN build -> no writes.
